bip_program_loader: RTL

//   Fills BIP program memory from a host byte stream (UART rx side) before execution.

---
 rtl/bip_program_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/bip_program_loader.sv
// Packs host byte pairs into instruction words, writes them to program memory and holds the CPU
// in reset until HLT is stored. Optional opcode range check: define LOADER_OPCODE_CHECK_EN.
module bip_program_loader #(
    parameter int unsigned OPCODE  = 5,
    parameter int unsigned OPERAND = 11,
    parameter int unsigned ADDR    = 11,
    parameter int unsigned BYTE    = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [BYTE-1:0]           i_RxData,
    input  logic                      i_RxDone,
    output logic                      o_WrEn,
    output logic [ADDR-1:0]           o_WrAddr,
    output logic [OPCODE+OPERAND-1:0] o_WrData,
    output logic                      o_CpuRst,
    output logic                      o_Done,
    output logic                      o_Err,
    output logic [ADDR:0]             o_Count
);

    localparam logic [OPCODE-1:0] OP_HLT = '0;
`ifdef LOADER_OPCODE_CHECK_EN
    localparam logic [OPCODE-1:0] OP_MAX = OPCODE'(7);
`endif

    typedef enum logic [2:0] {StHi, StLo, StWrite, StDone, StErr} state_e;

    state_e            stateQ, stateD;
    logic [BYTE-1:0]   hiQ, hiD;
    logic [BYTE-1:0]   loQ, loD;
    logic [ADDR-1:0]   addrQ, addrD;
    logic [ADDR:0]     countQ, countD;
    logic              errQ, errD;
    logic [OPCODE-1:0] opcode;
    logic              lastAddr;

    // Hi byte arrives first, so the opcode occupies its top bits.
    assign opcode   = hiQ[BYTE-1 -: OPCODE];
    assign lastAddr = (addrQ == {ADDR{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stateQ <= StHi;
            hiQ    <= '0;
            loQ    <= '0;
            addrQ  <= '0;
            countQ <= '0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            hiQ    <= hiD;
            loQ    <= loD;
            addrQ  <= addrD;
            countQ <= countD;
            errQ   <= errD;
        end
    end

    always_comb begin
        stateD = stateQ;
        hiD    = hiQ;
        loD    = loQ;
        addrD  = addrQ;
        countD = countQ;
        errD   = errQ;
        unique case (stateQ)
            StHi: begin
                if (i_RxDone) begin
                    hiD    = i_RxData;
                    stateD = StLo;
                end
            end
            StLo: begin
                if (i_RxDone) begin
                    loD    = i_RxData;
                    stateD = StWrite;
`ifdef LOADER_OPCODE_CHECK_EN
                    if (opcode > OP_MAX) begin
                        stateD = StErr;
                        errD   = 1'b1;
                    end
`endif
                end
            end
            StWrite: begin
                countD = countQ + (ADDR+1)'(1);
                if (opcode == OP_HLT) begin
                    stateD = StDone;
                end else if (lastAddr) begin
                    // Memory full without HLT: finish, but flag it.
                    stateD = StDone;
                    errD   = 1'b1;
                end else begin
                    addrD  = addrQ + ADDR'(1);
                    stateD = StHi;
                    // A strobe landing in the write cycle is the next word's hi byte.
                    if (i_RxDone) begin
                        hiD    = i_RxData;
                        stateD = StLo;
                    end
                end
            end
            StDone, StErr: begin
            end
            default: stateD = StHi;
        endcase
    end

    assign o_WrEn   = (stateQ == StWrite);
    assign o_WrAddr = addrQ;
    assign o_WrData = {hiQ, loQ};
    assign o_CpuRst = (stateQ != StDone);
    assign o_Done   = (stateQ == StDone);
    assign o_Err    = errQ;
    assign o_Count  = countQ;

endmodule
